// File: rtl/iob_axi2iob.sv
// AXI4-full slave to IOb native master bridge.
// Each AXI beat becomes one IOb transaction. INCR and FIXED bursts are supported.
// Only one AXI transaction is outstanding at a time. Reads and writes are arbitrated
// round-robin.
// Ports:
//   clk_i, rst_n_i      clock, synchronous active-low reset
//   s_axi_aw*/w*/b*     AXI write address, write data and write response channels
//   s_axi_ar*/r*        AXI read address and read data channels
//   iob_valid_o ...     IOb master request: addr, wdata and wstrb (wstrb 0 = read)
//   iob_ready_i         IOb request accepted
//   iob_rvalid_i/rdata  IOb read data return
module iob_axi2iob #(
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned AXI_ID_W  = 1,
  parameter int unsigned AXI_LEN_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [AXI_ID_W-1:0]   s_axi_awid_i,
  input  logic [ADDR_W-1:0]     s_axi_awaddr_i,
  input  logic [AXI_LEN_W-1:0]  s_axi_awlen_i,
  input  logic [2:0]            s_axi_awsize_i,
  input  logic [1:0]            s_axi_awburst_i,
  input  logic                  s_axi_awvalid_i,
  output logic                  s_axi_awready_o,
  input  logic [DATA_W-1:0]     s_axi_wdata_i,
  input  logic [DATA_W/8-1:0]   s_axi_wstrb_i,
  input  logic                  s_axi_wlast_i,
  input  logic                  s_axi_wvalid_i,
  output logic                  s_axi_wready_o,
  output logic [AXI_ID_W-1:0]   s_axi_bid_o,
  output logic [1:0]            s_axi_bresp_o,
  output logic                  s_axi_bvalid_o,
  input  logic                  s_axi_bready_i,
  input  logic [AXI_ID_W-1:0]   s_axi_arid_i,
  input  logic [ADDR_W-1:0]     s_axi_araddr_i,
  input  logic [AXI_LEN_W-1:0]  s_axi_arlen_i,
  input  logic [2:0]            s_axi_arsize_i,
  input  logic [1:0]            s_axi_arburst_i,
  input  logic                  s_axi_arvalid_i,
  output logic                  s_axi_arready_o,
  output logic [AXI_ID_W-1:0]   s_axi_rid_o,
  output logic [DATA_W-1:0]     s_axi_rdata_o,
  output logic [1:0]            s_axi_rresp_o,
  output logic                  s_axi_rlast_o,
  output logic                  s_axi_rvalid_o,
  input  logic                  s_axi_rready_i,
  output logic                  iob_valid_o,
  output logic [ADDR_W-1:0]     iob_addr_o,
  output logic [DATA_W-1:0]     iob_wdata_o,
  output logic [DATA_W/8-1:0]   iob_wstrb_o,
  input  logic                  iob_ready_i,
  input  logic                  iob_rvalid_i,
  input  logic [DATA_W-1:0]     iob_rdata_i
);

  localparam int unsigned StrbW    = DATA_W / 8;
  localparam logic [2:0]  SizeFull = 3'($clog2(StrbW));
  localparam logic [ADDR_W-1:0] AddrInc = ADDR_W'(StrbW);
  localparam logic [1:0]  BurstFixed = 2'b00;
  localparam logic [1:0]  BurstIncr  = 2'b01;
  localparam logic [1:0]  RespSlvErr = 2'b10;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StWData = 3'd1;
  localparam logic [2:0] StWResp = 3'd2;
  localparam logic [2:0] StRReq  = 3'd3;
  localparam logic [2:0] StRWait = 3'd4;
  localparam logic [2:0] StRData = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [AXI_ID_W-1:0]  id_q, id_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [AXI_LEN_W-1:0] len_q, len_d;
  logic [AXI_LEN_W-1:0] cnt_q, cnt_d;
  logic                 incr_q, incr_d;
  logic                 err_q, err_d;
  logic                 prio_rd_q, prio_rd_d;  // read wins the next simultaneous request
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 rgot_q, rgot_d;        // read data already captured in StRReq

  logic grant_w, grant_r, last_beat;

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    incr_d    = incr_q;
    err_d     = err_q;
    prio_rd_d = prio_rd_q;
    rdata_d   = rdata_q;
    rgot_d    = rgot_q;

    s_axi_awready_o = 1'b0;
    s_axi_arready_o = 1'b0;
    s_axi_wready_o  = 1'b0;
    s_axi_bvalid_o  = 1'b0;
    s_axi_bid_o     = '0;
    s_axi_bresp_o   = 2'b00;
    s_axi_rvalid_o  = 1'b0;
    s_axi_rid_o     = '0;
    s_axi_rdata_o   = '0;
    s_axi_rresp_o   = 2'b00;
    s_axi_rlast_o   = 1'b0;
    iob_valid_o     = 1'b0;
    iob_addr_o      = '0;
    iob_wdata_o     = '0;
    iob_wstrb_o     = '0;

    grant_w   = s_axi_awvalid_i & (~s_axi_arvalid_i | ~prio_rd_q);
    grant_r   = s_axi_arvalid_i & ~grant_w;
    last_beat = (cnt_q == len_q);

    case (state_q)
      StIdle: begin
        // Gated so no handshake is advertised while reset is being sampled.
        s_axi_awready_o = grant_w & rst_n_i;
        s_axi_arready_o = grant_r & rst_n_i;
        if (grant_w) begin
          id_d      = s_axi_awid_i;
          addr_d    = s_axi_awaddr_i;
          len_d     = s_axi_awlen_i;
          incr_d    = (s_axi_awburst_i == BurstIncr);
          err_d     = ((s_axi_awburst_i != BurstIncr) && (s_axi_awburst_i != BurstFixed)) ||
                      (s_axi_awsize_i != SizeFull);
          cnt_d     = '0;
          prio_rd_d = 1'b1;
          state_d   = StWData;
        end else if (grant_r) begin
          id_d      = s_axi_arid_i;
          addr_d    = s_axi_araddr_i;
          len_d     = s_axi_arlen_i;
          incr_d    = (s_axi_arburst_i == BurstIncr);
          err_d     = ((s_axi_arburst_i != BurstIncr) && (s_axi_arburst_i != BurstFixed)) ||
                      (s_axi_arsize_i != SizeFull);
          cnt_d     = '0;
          rgot_d    = 1'b0;
          prio_rd_d = 1'b0;
          state_d   = StRReq;
        end
      end

      StWData: begin
        if (err_q) begin
          s_axi_wready_o = 1'b1;  // drain beats without touching IOb
        end else begin
          s_axi_wready_o = iob_ready_i;
          iob_valid_o    = s_axi_wvalid_i;
          iob_addr_o     = addr_q;
          iob_wdata_o    = s_axi_wdata_i;
          iob_wstrb_o    = s_axi_wstrb_i;
        end
        if (s_axi_wvalid_i && s_axi_wready_o) begin
          cnt_d = cnt_q + AXI_LEN_W'(1);
          if (incr_q) addr_d = addr_q + AddrInc;
          if (s_axi_wlast_i != last_beat) err_d = 1'b1;
          if (last_beat) state_d = StWResp;
        end
      end

      StWResp: begin
        s_axi_bvalid_o = 1'b1;
        s_axi_bid_o    = id_q;
        s_axi_bresp_o  = err_q ? RespSlvErr : 2'b00;
        if (s_axi_bready_i) state_d = StIdle;
      end

      StRReq: begin
        if (err_q) begin
          rdata_d = '0;
          state_d = StRData;
        end else begin
          iob_valid_o = 1'b1;
          iob_addr_o  = addr_q;
          if (iob_ready_i) begin
            state_d = StRWait;
            if (iob_rvalid_i) begin
              rdata_d = iob_rdata_i;
              rgot_d  = 1'b1;
            end
          end
        end
      end

      StRWait: begin
        if (rgot_q || iob_rvalid_i) begin
          if (!rgot_q) rdata_d = iob_rdata_i;
          rgot_d  = 1'b0;
          state_d = StRData;
        end
      end

      StRData: begin
        s_axi_rvalid_o = 1'b1;
        s_axi_rid_o    = id_q;
        s_axi_rdata_o  = rdata_q;
        s_axi_rresp_o  = err_q ? RespSlvErr : 2'b00;
        s_axi_rlast_o  = last_beat;
        if (s_axi_rready_i) begin
          if (last_beat) begin
            state_d = StIdle;
          end else begin
            cnt_d   = cnt_q + AXI_LEN_W'(1);
            if (incr_q) addr_d = addr_q + AddrInc;
            rgot_d  = 1'b0;
            state_d = StRReq;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= StIdle;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      incr_q    <= 1'b0;
      err_q     <= 1'b0;
      prio_rd_q <= 1'b0;
      rdata_q   <= '0;
      rgot_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      incr_q    <= incr_d;
      err_q     <= err_d;
      prio_rd_q <= prio_rd_d;
      rdata_q   <= rdata_d;
      rgot_q    <= rgot_d;
    end
  end

endmodule

// File: tb/tb_iob_axi2iob.sv
// Self-checking bench for iob_axi2iob: directed vector table, hand-written corner
// sequences (arbitration, reset mid-burst) and randomized transactions checked against
// a transaction-level model with its own memory image.
module tb_iob_axi2iob;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        awid, arid, bid, rid;
  logic [23:0] awaddr, araddr, iob_addr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, arvalid, arready;
  logic [31:0] wdata, rdata, iob_wdata, iob_rdata;
  logic [3:0]  wstrb, iob_wstrb;
  logic        wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;
  logic        iob_valid, iob_ready, iob_rvalid;

  always #5 clk = ~clk;

  iob_axi2iob #(.ADDR_W(24), .DATA_W(32), .AXI_ID_W(1), .AXI_LEN_W(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .s_axi_awid_i(awid), .s_axi_awaddr_i(awaddr), .s_axi_awlen_i(awlen),
    .s_axi_awsize_i(awsize), .s_axi_awburst_i(awburst), .s_axi_awvalid_i(awvalid),
    .s_axi_awready_o(awready),
    .s_axi_wdata_i(wdata), .s_axi_wstrb_i(wstrb), .s_axi_wlast_i(wlast),
    .s_axi_wvalid_i(wvalid), .s_axi_wready_o(wready),
    .s_axi_bid_o(bid), .s_axi_bresp_o(bresp), .s_axi_bvalid_o(bvalid),
    .s_axi_bready_i(bready),
    .s_axi_arid_i(arid), .s_axi_araddr_i(araddr), .s_axi_arlen_i(arlen),
    .s_axi_arsize_i(arsize), .s_axi_arburst_i(arburst), .s_axi_arvalid_i(arvalid),
    .s_axi_arready_o(arready),
    .s_axi_rid_o(rid), .s_axi_rdata_o(rdata), .s_axi_rresp_o(rresp),
    .s_axi_rlast_o(rlast), .s_axi_rvalid_o(rvalid), .s_axi_rready_i(rready),
    .iob_valid_o(iob_valid), .iob_addr_o(iob_addr), .iob_wdata_o(iob_wdata),
    .iob_wstrb_o(iob_wstrb), .iob_ready_i(iob_ready), .iob_rvalid_i(iob_rvalid),
    .iob_rdata_i(iob_rdata)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout want handshake", name);
  endtask

  typedef struct packed {
    logic [23:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } iob_t;

  iob_t        obs_q[$];
  iob_t        exp_q[$];
  logic [31:0] slv_mem[logic [23:0]];
  logic [31:0] ref_mem[logic [23:0]];
  logic [31:0] wdat[256];
  logic [31:0] rexp[256];
  bit          bp = 1'b0;
  bit          rd_pend = 1'b0;
  logic [23:0] rd_addr;
  bit          stall_seen = 1'b0;
  logic [23:0] held_addr;
  logic [31:0] held_data;

  // IOb memory slave and request monitor.
  always @(posedge clk) begin
    if (!rst_n) begin
      stall_seen = 1'b0;
      rd_pend    = 1'b0;
    end else begin
      if (stall_seen) begin
        chk("iob_hold_valid", iob_valid, 1);
        chk("iob_hold_addr", iob_addr, held_addr);
        chk("iob_hold_wdata", iob_wdata, held_data);
      end
      stall_seen = iob_valid && !iob_ready;
      held_addr  = iob_addr;
      held_data  = iob_wdata;
      if (iob_valid && iob_ready) begin
        obs_q.push_back('{iob_addr, iob_wdata, iob_wstrb});
        if (iob_wstrb != 4'h0) slv_mem[iob_addr] = iob_wdata;
        else begin
          rd_pend = 1'b1;
          rd_addr = iob_addr;
        end
      end
    end
  end

  always @(negedge clk) begin
    iob_rvalid = rd_pend;
    iob_rdata  = (rd_pend && slv_mem.exists(rd_addr)) ? slv_mem[rd_addr] : 32'h0;
    rd_pend    = 1'b0;
    iob_ready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Reference model: expected IOb traffic and AXI response per transaction.
  function automatic logic [23:0] beat_addr(input logic [23:0] a, input logic [1:0] b,
                                            input int k);
    return (b == 2'b01) ? a + 24'(4 * k) : a;
  endfunction

  task automatic model_write(input logic [23:0] a, input logic [7:0] l, input logic [2:0] sz,
                             input logic [1:0] b, input int wlast_at, output logic [1:0] resp);
    bit err;
    err = (b > 2'b01) || (sz != 3'd2);
    for (int k = 0; k <= int'(l); k++) begin
      if (!err) begin
        exp_q.push_back('{beat_addr(a, b, k), wdat[k], 4'hF});
        ref_mem[beat_addr(a, b, k)] = wdat[k];
      end
      if ((k == wlast_at) != (k == int'(l))) err = 1'b1;
    end
    resp = err ? 2'b10 : 2'b00;
  endtask

  task automatic model_read(input logic [23:0] a, input logic [7:0] l, input logic [2:0] sz,
                            input logic [1:0] b, output logic [1:0] resp);
    bit err;
    err = (b > 2'b01) || (sz != 3'd2);
    for (int k = 0; k <= int'(l); k++) begin
      if (!err) begin
        exp_q.push_back('{beat_addr(a, b, k), 32'h0, 4'h0});
        rexp[k] = ref_mem.exists(beat_addr(a, b, k)) ? ref_mem[beat_addr(a, b, k)] : 32'h0;
      end else begin
        rexp[k] = 32'h0;
      end
    end
    resp = err ? 2'b10 : 2'b00;
  endtask

  // AXI master phases; each starts and ends just after a falling edge.
  task automatic wait_aw();
    for (int n = 0; n < 100; n++) begin
      #1;
      if (awready) begin
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    fail("aw_timeout");
    awvalid = 1'b0;
  endtask

  task automatic wait_ar();
    for (int n = 0; n < 100; n++) begin
      #1;
      if (arready) begin
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    fail("ar_timeout");
    arvalid = 1'b0;
  endtask

  task automatic w_phase(input int nb, input int wlast_at, output int stalls);
    bit done;
    stalls = 0;
    for (int k = 0; k < nb; k++) begin
      if (bp && $urandom_range(0, 2) == 0) begin
        wvalid = 1'b0;
        @(negedge clk);
      end
      wvalid = 1'b1;
      wdata  = wdat[k];
      wstrb  = 4'hF;
      wlast  = (k == wlast_at);
      done   = 1'b0;
      for (int n = 0; n < 100 && !done; n++) begin
        #1;
        if (wready) begin
          done = 1'b1;
          @(posedge clk);
          @(negedge clk);
        end else begin
          stalls++;
          @(negedge clk);
        end
      end
      if (!done) fail("w_timeout");
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  task automatic b_phase(input logic eid, input logic [1:0] eresp, input string tag,
                         output logic [1:0] oresp);
    oresp = 2'bxx;
    for (int n = 0; n < 200; n++) begin
      bready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (bvalid && bready) begin
        chk({tag, "_bid"}, bid, eid);
        chk({tag, "_bresp"}, bresp, eresp);
        oresp = bresp;
        @(posedge clk);
        @(negedge clk);
        bready = 1'b0;
        return;
      end
      @(negedge clk);
    end
    fail({tag, "_b_timeout"});
    bready = 1'b0;
  endtask

  task automatic r_phase(input int nb, input logic eid, input logic [1:0] eresp,
                         input string tag, output logic [1:0] oresp);
    int k;
    k = 0;
    oresp = 2'bxx;
    for (int n = 0; n < 2000 && k < nb; n++) begin
      rready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (rvalid && rready) begin
        chk($sformatf("%s_rdata%0d", tag, k), rdata, rexp[k]);
        chk({tag, "_rresp"}, rresp, eresp);
        chk({tag, "_rid"}, rid, eid);
        chk($sformatf("%s_rlast%0d", tag, k), rlast, (k == nb - 1));
        oresp = rresp;
        k++;
        @(posedge clk);
        @(negedge clk);
      end else begin
        @(negedge clk);
      end
    end
    rready = 1'b0;
    if (k < nb) fail({tag, "_r_timeout"});
    else chk({tag, "_rvalid_after_last"}, rvalid, 0);
  endtask

  task automatic check_iob(input string tag, output int n, output logic [23:0] last_a);
    n      = obs_q.size();
    last_a = (n > 0) ? obs_q[n-1].addr : 24'h0;
    chk({tag, "_iob_cnt"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      chk($sformatf("%s_iob%0d_addr", tag, i), obs_q[i].addr, exp_q[i].addr);
      chk($sformatf("%s_iob%0d_wdata", tag, i), obs_q[i].data, exp_q[i].data);
      chk($sformatf("%s_iob%0d_wstrb", tag, i), obs_q[i].strb, exp_q[i].strb);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic run_txn(input bit wr, input logic id, input logic [23:0] a, input logic [7:0] l,
                         input logic [2:0] sz, input logic [1:0] b, input int wlast_at,
                         input string tag, output logic [1:0] oresp, output int stalls,
                         output int niob, output logic [23:0] last_a);
    logic [1:0] mresp;
    stalls = 0;
    if (wr) begin
      model_write(a, l, sz, b, wlast_at, mresp);
      awid = id; awaddr = a; awlen = l; awsize = sz; awburst = b; awvalid = 1'b1;
      wait_aw();
      w_phase(int'(l) + 1, wlast_at, stalls);
      b_phase(id, mresp, tag, oresp);
    end else begin
      model_read(a, l, sz, b, mresp);
      arid = id; araddr = a; arlen = l; arsize = sz; arburst = b; arvalid = 1'b1;
      wait_ar();
      r_phase(int'(l) + 1, id, mresp, tag, oresp);
    end
    check_iob(tag, niob, last_a);
  endtask

  typedef struct {
    bit          wr;
    logic        id;
    logic [23:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          wlast_at;
    logic [1:0]  eresp;
    int          niob;
    logic [23:0] last_addr;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  oresp;
    int          stalls, niob;
    logic [23:0] last_a;

    awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awvalid = 0;
    wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
    arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arvalid = 0; rready = 0;
    iob_ready = 1; iob_rvalid = 0; iob_rdata = 0;

    //               wr id addr      len  sz  burst wl resp niob last
    vecs[0]  = '{1, 1, 24'h000100, 8'd3, 3'd2, 2'd1, 3, 2'd0, 4, 24'h00010C};
    vecs[1]  = '{0, 0, 24'h000100, 8'd3, 3'd2, 2'd1, 0, 2'd0, 4, 24'h00010C};
    vecs[2]  = '{1, 0, 24'h000020, 8'd2, 3'd2, 2'd0, 2, 2'd0, 3, 24'h000020};
    vecs[3]  = '{0, 1, 24'h000020, 8'd2, 3'd2, 2'd0, 0, 2'd0, 3, 24'h000020};
    vecs[4]  = '{1, 1, 24'h000040, 8'd1, 3'd2, 2'd2, 1, 2'd2, 0, 24'h000000};
    vecs[5]  = '{0, 0, 24'h000040, 8'd1, 3'd2, 2'd2, 0, 2'd2, 0, 24'h000000};
    vecs[6]  = '{1, 0, 24'h000080, 8'd0, 3'd1, 2'd1, 0, 2'd2, 0, 24'h000000};
    vecs[7]  = '{1, 1, 24'h000200, 8'd2, 3'd2, 2'd1, 0, 2'd2, 1, 24'h000200};
    vecs[8]  = '{1, 0, 24'h000300, 8'd1, 3'd2, 2'd1, -1, 2'd2, 2, 24'h000304};
    vecs[9]  = '{1, 1, 24'hFFFFFC, 8'd1, 3'd2, 2'd1, 1, 2'd0, 2, 24'h000000};
    vecs[10] = '{0, 1, 24'h000300, 8'd0, 3'd2, 2'd3, 0, 2'd2, 0, 24'h000000};

    // Reset state, with requests pending that must not be acknowledged.
    repeat (3) @(negedge clk);
    awvalid = 1'b1;
    arvalid = 1'b1;
    #1;
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_iob_valid", iob_valid, 0);
    chk("rst_iob_wstrb", iob_wstrb, 0);
    chk("rst_resp_id", {bresp, rresp, bid, rid}, 0);
    chk("rst_rdata", rdata, 0);
    awvalid = 1'b0;
    arvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vector table, IOb always ready.
    for (int k = 0; k < 256; k++) wdat[k] = 32'hA0 + 32'(k);
    for (int i = 0; i < 11; i++) begin
      run_txn(vecs[i].wr, vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst,
              vecs[i].wlast_at, $sformatf("vec%0d", i), oresp, stalls, niob, last_a);
      chk($sformatf("vec%0d_resp", i), oresp, vecs[i].eresp);
      chk($sformatf("vec%0d_niob", i), niob, vecs[i].niob);
      if (niob > 0) chk($sformatf("vec%0d_last_addr", i), last_a, vecs[i].last_addr);
      if (vecs[i].wr) chk($sformatf("vec%0d_w_stalls", i), stalls, 0);
    end

    // Randomized traffic, second half with backpressure on every channel.
    for (int t = 0; t < 60; t++) begin
      logic [23:0] a;
      logic [7:0]  l;
      logic [1:0]  b;
      logic [2:0]  sz;
      int          r, wl;
      bp = (t >= 30);
      a  = 24'($urandom_range(0, 63) * 4);
      if ($urandom_range(0, 9) == 0) a = 24'hFFFFF0 | 24'($urandom_range(0, 3) * 4);
      l  = 8'($urandom_range(0, 7));
      r  = $urandom_range(0, 9);
      b  = (r < 8) ? 2'(r % 2) : 2'(r - 6);
      sz = ($urandom_range(0, 15) == 0) ? 3'd1 : 3'd2;
      wl = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, int'(l) + 1)) - 1 : int'(l);
      for (int k = 0; k < 256; k++) wdat[k] = $urandom;
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, l, sz, b, wl,
              $sformatf("rnd%0d", t), oresp, stalls, niob, last_a);
    end
    bp = 1'b0;
    @(negedge clk);

    // Reset in the middle of a read burst aborts it with no completion.
    arid = 0; araddr = 24'h100; arlen = 8'd7; arsize = 3'd2; arburst = 2'd1; arvalid = 1'b1;
    wait_ar();
    rready = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("midrst_rvalid_before", rvalid, 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_rvalid_after", rvalid, 0);
    chk("midrst_iob_valid", iob_valid, 0);
    chk("midrst_bvalid", bvalid, 0);
    rst_n = 1'b1;
    obs_q.delete();
    exp_q.delete();
    @(negedge clk);

    // Simultaneous requests after reset: write first, then read.
    for (int k = 0; k < 256; k++) wdat[k] = 32'h5000 + 32'(k);
    model_write(24'h180, 8'd0, 3'd2, 2'd1, 0, oresp);
    awid = 1; awaddr = 24'h180; awlen = 0; awsize = 3'd2; awburst = 2'd1; awvalid = 1'b1;
    arid = 0; araddr = 24'h180; arlen = 0; arsize = 3'd2; arburst = 2'd1; arvalid = 1'b1;
    #1;
    chk("arb1_awready", awready, 1);
    chk("arb1_arready", arready, 0);
    wait_aw();
    arvalid = 1'b0;
    w_phase(1, 0, stalls);
    b_phase(1, 2'b00, "arb1", oresp);
    check_iob("arb1", niob, last_a);

    model_read(24'h180, 8'd0, 3'd2, 2'd1, oresp);
    awid = 0; awaddr = 24'h1C0; awvalid = 1'b1;
    arid = 1; araddr = 24'h180; arvalid = 1'b1;
    #1;
    chk("arb2_arready", arready, 1);
    chk("arb2_awready", awready, 0);
    wait_ar();
    awvalid = 1'b0;
    r_phase(1, 1, 2'b00, "arb2", oresp);
    check_iob("arb2", niob, last_a);
    chk("arb2_readback", rexp[0], 32'h5000);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iob_axi2iob.md
Name: iob_axi2iob

Overview:
- AXI4-full slave to IOb native master bridge; the reverse of the IOb-to-AXI bridge.
- Lets an AXI master (DMA, CPU interconnect) access IOb peripherals and memories.
- Converts INCR and FIXED bursts into single IOb transactions, one beat at a time.
- Single outstanding AXI transaction; reads and writes are arbitrated round-robin.

Parameters:
ADDR_W, 24, IOb and AXI byte-address width
DATA_W, 32, data width; only full-width beats are supported
AXI_ID_W, 1, AXI ID width
AXI_LEN_W, 8, AXI burst length field width

Ports:
clk_i  in  1  clock
rst_n_i  in  1  synchronous active-low reset
s_axi_awid_i / awaddr_i / awlen_i / awsize_i / awburst_i  in  AXI_ID_W/ADDR_W/AXI_LEN_W/3/2  write address channel
s_axi_awvalid_i in 1; s_axi_awready_o out 1  write address handshake
s_axi_wdata_i / wstrb_i / wlast_i / wvalid_i  in  DATA_W/DATA_W/8/1/1  write data channel
s_axi_wready_o  out  1  write data ready
s_axi_bid_o / bresp_o / bvalid_o  out  AXI_ID_W/2/1  write response channel
s_axi_bready_i  in  1  write response ready
s_axi_arid_i / araddr_i / arlen_i / arsize_i / arburst_i / arvalid_i  in  as aw*  read address channel
s_axi_arready_o  out  1  read address ready
s_axi_rid_o / rdata_o / rresp_o / rlast_o / rvalid_o  out  AXI_ID_W/DATA_W/2/1/1  read data channel
s_axi_rready_i  in  1  read data ready
iob_valid_o  out  1  IOb request valid
iob_addr_o  out  ADDR_W  IOb byte address
iob_wdata_o / iob_wstrb_o  out  DATA_W/DATA_W/8  write data and strobe (strobe 0 means read)
iob_ready_i  in  1  request accepted
iob_rvalid_i / iob_rdata_i  in  1/DATA_W  read data return

Behaviour:
- Reset, sampled on rising clk_i while rst_n_i=0: FSM to IDLE; all *valid_o, *ready_o, rlast_o, iob_wstrb_o = 0; resp/id/data outputs = 0.
- Reset asserted mid-burst aborts the burst immediately. No B or R completion is issued.
- FSM states: IDLE, W_DATA, W_RESP, R_REQ, R_WAIT, R_DATA.
- IDLE: awready_o/arready_o asserted combinationally only for the granted channel.
  - Only one of awvalid/arvalid set: grant that channel.
  - Both set: grant the channel not granted last time (priority flag resets to write-first).
  - On handshake, register id, addr, len, burst; clear beat counter.
  - If burst = WRAP or reserved, set error flag.
  - awsize/arsize other than log2(DATA_W/8) also sets error.
- W_DATA:
  - No error: iob_valid_o = wvalid_i, with addr/wdata/wstrb passed through.
  - wready_o = iob_ready_i, so AXI and IOb transfer in the same cycle.
  - Error set: wready_o = 1 and iob_valid_o = 0 (beats are drained).
  - Each accepted beat increments the counter. Address advances by DATA_W/8 for INCR and holds for FIXED.
  - After beat awlen+1: go to W_RESP.
  - wlast_i disagreeing with the counter (early or missing) sets error; the count still governs termination.
- W_RESP: bvalid_o=1, bid_o = stored id, bresp_o = 2'b10 (SLVERR) if error else 2'b00. On bready_i go to IDLE.
- R_REQ: iob_valid_o=1, wstrb=0. On iob_ready_i go to R_WAIT.
  - Error set: skip the IOb access and go straight to R_DATA with rdata 0.
- R_WAIT: wait for iob_rvalid_i. Register iob_rdata_i (the IOb response may arrive in the same cycle as ready, or later), then go to R_DATA.
- R_DATA: rvalid_o=1, rid_o = id, rresp as bresp, rlast_o=1 on beat arlen+1.
  - On rready_i: if last beat go to IDLE, else advance address and go to R_REQ.
- Latency: write beat = 1 cycle when iob_ready_i=1. Read beat >= 3 cycles (R_REQ, R_WAIT, R_DATA).
- Address arithmetic wraps modulo 2^ADDR_W. 4KB boundary crossing is not checked.
- iob_valid_o is held with addr/data stable until iob_ready_i.

Test Plan:
- INCR write: awaddr=0x100, awlen=3, data 0xA0..0xA3, wstrb=0xF, iob_ready=1 -> IOb writes to 0x100,0x104,0x108,0x10C, one per cycle; bresp=00, bid echoed.
- INCR read back from the same address, IOb memory with 1-cycle rvalid -> rdata 0xA0..0xA3, rlast only on beat 4, rresp=00.
- Backpressure: iob_ready toggling 1/0 and rready low 3 cycles -> no beat lost or duplicated; iob_addr/wdata stable while stalled.
- FIXED read, awlen=2, addr 0x20 -> three IOb reads all at 0x20.
- WRAP write, awlen=1 -> zero iob_valid pulses, 2 beats drained, bresp=2'b10.
- awvalid and arvalid asserted together twice -> write granted first, read granted second; reset asserted mid-read-burst -> rvalid_o=0 next cycle, FSM in IDLE.
